// File: rtl/iddmm_pkg.sv
// iddmm_pkg: shared state encoding, mode constants and default sizes
// for the word-serial CIOS Montgomery multiplier.
package iddmm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      QCALC,
      RED,
      SUB,
      OUT
   } state_t;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_SQR = 1'b1;

   localparam int K_DEF = 128;
   localparam int N_DEF = 32;

endpackage

// File: rtl/iddmm_mac.sv
// iddmm_mac: single K x K multiply-accumulate, {hi,lo} = a*b + t + cin.
// The worst case (2^K-1)^2 + 2*(2^K-1) still fits in 2K bits.
module iddmm_mac #(
   parameter int K = 128
) (
   input  logic [K-1:0]   a_i,
   input  logic [K-1:0]   b_i,
   input  logic [K-1:0]   t_i,
   input  logic [K-1:0]   cin_i,
   output logic [2*K-1:0] sum_o
);

   logic [2*K-1:0] prod;

   assign prod  = {{K{1'b0}}, a_i} * {{K{1'b0}}, b_i};
   assign sum_o = prod + {{K{1'b0}}, t_i} + {{K{1'b0}}, cin_i};

endmodule

// File: rtl/iddmm_core_mode.sv
// iddmm_core_mode: word-serial CIOS Montgomery multiplier with square
// mode, computing x*y*R^-1 mod M and streaming N result words out.
module iddmm_core_mode
   import iddmm_pkg::*;
#(
   parameter int K      = K_DEF,
   parameter int N      = N_DEF,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        wr_ena,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [K-1:0]      wr_x,
   input  logic [K-1:0]      wr_y,
   input  logic [K-1:0]      wr_m,
   input  logic [K-1:0]      wr_m1,
   input  logic              task_req,
   input  logic              task_mode,
   output logic              task_busy,
   output logic              task_grant,
   output logic [K-1:0]      task_res,
   output logic              task_end
);

   localparam int JW = ADDR_W + 1;

   logic [K-1:0] x_q [N];
   logic [K-1:0] y_q [N];
   logic [K-1:0] m_q [N];
   logic [K-1:0] m1_q;
   logic [K-1:0] t_q [N];
   logic [K-1:0] d_q [N];
   logic [K-1:0] tn_q, c_q, q_q, res_q;
   logic         tn1_q, brw_q, sel_q, mode_q;
   logic         busy_q, grant_q, end_q;
   logic [ADDR_W-1:0] i_q;
   logic [JW-1:0]     j_q;
   state_t            st_q;

   logic [ADDR_W-1:0] ja, jp, jn;
   logic              tail_j, last_w, bin, sel_now;
   logic [K-1:0]      mac_a, mac_b, mac_t, mac_c, word0;
   logic [2*K-1:0]    mac_s;
   logic [K:0]        tail, dif;

   assign ja     = j_q[ADDR_W-1:0];
   assign jp     = ja - ADDR_W'(1);
   assign jn     = ja + ADDR_W'(1);
   assign tail_j = (j_q == JW'(N));
   assign last_w = (j_q == JW'(N-1));
   assign bin    = (j_q == '0) ? 1'b0 : brw_q;

   always_ff @(posedge clk) begin
      if (!busy_q && (int'(wr_addr) < N)) begin
         if (wr_ena[0]) x_q[wr_addr] <= wr_x;
         if (wr_ena[1]) y_q[wr_addr] <= wr_y;
         if (wr_ena[2]) begin
            m_q[wr_addr] <= wr_m;
            m1_q         <= wr_m1;
         end
      end
   end

   // One multiplier shared by all phases; carry-in is zero on word 0.
   always_comb begin
      mac_a = q_q;
      mac_b = m_q[ja];
      mac_t = t_q[ja];
      mac_c = (j_q == '0) ? '0 : c_q;
      case (st_q)
         MUL: begin
            mac_a = x_q[i_q];
            mac_b = (mode_q == MODE_SQR) ? x_q[ja] : y_q[ja];
         end
         QCALC: begin
            mac_a = t_q[0];
            mac_b = m1_q;
            mac_t = '0;
            mac_c = '0;
         end
         default: ;
      endcase
   end

   iddmm_mac #(.K(K)) u_mac (
      .a_i   (mac_a),
      .b_i   (mac_b),
      .t_i   (mac_t),
      .cin_i (mac_c),
      .sum_o (mac_s)
   );

   assign tail    = {1'b0, tn_q} + {1'b0, c_q};
   assign dif     = {1'b0, t_q[ja]} - {1'b0, m_q[ja]} - {{K{1'b0}}, bin};
   assign sel_now = (tn_q != '0) | !dif[K];
   assign word0   = sel_now ? d_q[0] : t_q[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q    <= IDLE;
         busy_q  <= 1'b0;
         grant_q <= 1'b0;
         end_q   <= 1'b0;
         res_q   <= '0;
         i_q     <= '0;
         j_q     <= '0;
      end else begin
         unique case (st_q)
            IDLE: if (task_req) begin
               for (int k = 0; k < N; k++) t_q[k] <= '0;
               tn_q   <= '0;
               tn1_q  <= 1'b0;
               i_q    <= '0;
               j_q    <= '0;
               mode_q <= task_mode;
               busy_q <= 1'b1;
               st_q   <= MUL;
            end
            MUL: if (tail_j) begin
               tn_q  <= tail[K-1:0];
               tn1_q <= tail[K];
               j_q   <= '0;
               st_q  <= QCALC;
            end else begin
               t_q[ja] <= mac_s[K-1:0];
               c_q     <= mac_s[2*K-1:K];
               j_q     <= j_q + JW'(1);
            end
            QCALC: begin
               q_q  <= mac_s[K-1:0];
               st_q <= RED;
            end
            RED: if (tail_j) begin
               t_q[ADDR_W'(N-1)] <= tail[K-1:0];
               tn_q <= K'(tn1_q) + K'(tail[K]);
               j_q  <= '0;
               i_q  <= i_q + ADDR_W'(1);
               st_q <= (i_q == ADDR_W'(N-1)) ? SUB : MUL;
            end else begin
               if (j_q != '0) t_q[jp] <= mac_s[K-1:0];
               c_q <= mac_s[2*K-1:K];
               j_q <= j_q + JW'(1);
            end
            SUB: begin
               d_q[ja] <= dif[K-1:0];
               brw_q   <= dif[K];
               if (last_w) begin
                  sel_q   <= sel_now;
                  res_q   <= word0;
                  grant_q <= 1'b1;
                  end_q   <= 1'b0;
                  j_q     <= '0;
                  st_q    <= OUT;
               end else begin
                  j_q <= j_q + JW'(1);
               end
            end
            OUT: if (last_w) begin
               grant_q <= 1'b0;
               end_q   <= 1'b0;
               busy_q  <= 1'b0;
               res_q   <= '0;
               j_q     <= '0;
               st_q    <= IDLE;
            end else begin
               res_q <= sel_q ? d_q[jn] : t_q[jn];
               end_q <= (jn == ADDR_W'(N-1));
               j_q   <= j_q + JW'(1);
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   assign task_busy  = busy_q;
   assign task_grant = grant_q;
   assign task_res   = res_q;
   assign task_end   = end_q;

endmodule
